// File: rtl/diff_pkg.sv
// Shared definitions for the DIFF scan execution unit: default operand
// width, result width, the "no difference" code and the FSM state type.
package diff_pkg;

  localparam int DIFF_WIDTH = 32;
  localparam int DIFF_RES_W = $clog2(DIFF_WIDTH) + 1;
  localparam int DIFF_NONE  = DIFF_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } diff_state_t;

  // Index width for n items; never zero so degenerate sizes still get a 1-bit field.
  function automatic int diff_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/diff_chunk_prio.sv
// Combinational CHUNK-bit priority chain. Each cell claims its own index
// when its bit is set and no lower cell (or the incoming carry) has already
// claimed; the carry ORs forward so c_out = c_in | (bits != 0).
module diff_chunk_prio
  import diff_pkg::*;
#(
  parameter int CHUNK = 8,
  parameter int POS_W = diff_idx_w(CHUNK)
) (
  input  logic             c_in,
  input  logic [CHUNK-1:0] bits,
  output logic [POS_W-1:0] pos,
  output logic             c_out
);

  logic [CHUNK:0]   carry;
  logic [CHUNK-1:0] sel;

  assign carry[0] = c_in;

  generate
    for (genvar gi = 0; gi < CHUNK; gi++) begin : g_cell
      assign sel[gi]     = bits[gi] & ~carry[gi];
      assign carry[gi+1] = carry[gi] | bits[gi];
    end
  endgenerate

  assign c_out = carry[CHUNK];

  // At most one cell is selected, so OR-ing the selected indices encodes it.
  always_comb begin
    pos = '0;
    for (int i = 0; i < CHUNK; i++) begin
      if (sel[i]) pos = pos | POS_W'(i);
    end
  end

endmodule

// File: rtl/diff_scan_unit.sv
// DIFF instruction unit: finds the lowest bit index where op_a and op_b
// differ (or WIDTH when equal) by scanning the XOR CHUNK bits per cycle.
// Optional macro DIFF_SCAN_EARLY_EXIT_EN ends the scan on the first hit;
// without it the latency is fixed at WIDTH/CHUNK+1 cycles.
module diff_scan_unit
  import diff_pkg::*;
#(
  parameter int WIDTH = DIFF_WIDTH,
  parameter int CHUNK = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [WIDTH-1:0]       op_a,
  input  logic [WIDTH-1:0]       op_b,
  output logic                   busy,
  output logic [$clog2(WIDTH):0] result,
  output logic                   result_valid,
  input  logic                   result_ack
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = diff_idx_w(NCHUNK);
  localparam int POS_W  = diff_idx_w(CHUNK);
  localparam int RES_W  = $clog2(WIDTH) + 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);
  localparam logic [RES_W-1:0] NONE_R   = RES_W'(WIDTH);
  localparam logic [RES_W-1:0] CHUNK_R  = RES_W'(CHUNK);

  diff_state_t      state_reg, state_next;
  logic [WIDTH-1:0] diff_reg, diff_next;
  logic [IDX_W-1:0] chunk_idx_reg, chunk_idx_next;
  logic             found_reg, found_next;
  logic [RES_W-1:0] result_reg, result_next;
  logic             valid_reg, valid_next;

  logic [CHUNK-1:0] chunk_words [NCHUNK];
  logic [CHUNK-1:0] cur_chunk;
  logic [POS_W-1:0] chunk_pos;
  logic             chunk_c_out;
  logic             first_hit;
  logic [RES_W-1:0] hit_index;

  generate
    for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_word
      assign chunk_words[gi] = diff_reg[gi*CHUNK +: CHUNK];
    end
  endgenerate

  assign cur_chunk = chunk_words[chunk_idx_reg];

  // The found register is the carry into the chain, so a chunk after the
  // first hit can never claim a position.
  diff_chunk_prio #(
    .CHUNK (CHUNK),
    .POS_W (POS_W)
  ) u_prio (
    .c_in  (found_reg),
    .bits  (cur_chunk),
    .pos   (chunk_pos),
    .c_out (chunk_c_out)
  );

  assign first_hit = chunk_c_out & ~found_reg;
  assign hit_index = RES_W'(chunk_idx_reg) * CHUNK_R + RES_W'(chunk_pos);

  // Next-state logic for the IDLE -> SCAN -> DONE sequence.
  always_comb begin
    state_next     = state_reg;
    diff_next      = diff_reg;
    chunk_idx_next = chunk_idx_reg;
    found_next     = found_reg;
    result_next    = result_reg;
    valid_next     = valid_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          diff_next      = op_a ^ op_b;
          chunk_idx_next = '0;
          found_next     = 1'b0;
          state_next     = SCAN;
        end
      end
      SCAN: begin
        found_next     = chunk_c_out;
        chunk_idx_next = chunk_idx_reg + 1'b1;
        if (first_hit) result_next = hit_index;
        if (chunk_idx_reg == LAST_IDX) begin
          state_next = DONE;
          valid_next = 1'b1;
          if (!chunk_c_out) result_next = NONE_R;
        end
`ifdef DIFF_SCAN_EARLY_EXIT_EN
        else if (first_hit) begin
          state_next = DONE;
          valid_next = 1'b1;
        end
`endif
      end
      DONE: begin
        // A start arriving with the ack is not seen: it is only sampled in IDLE.
        if (result_ack) begin
          state_next = IDLE;
          valid_next = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        valid_next = 1'b0;
      end
    endcase
  end

  // State registers; reset discards any scan or pending result at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      diff_reg      <= '0;
      chunk_idx_reg <= '0;
      found_reg     <= 1'b0;
      result_reg    <= '0;
      valid_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      diff_reg      <= diff_next;
      chunk_idx_reg <= chunk_idx_next;
      found_reg     <= found_next;
      result_reg    <= result_next;
      valid_reg     <= valid_next;
    end
  end

  assign busy         = (state_reg != IDLE);
  assign result       = result_reg;
  assign result_valid = valid_reg;

endmodule

// File: tb/tb_diff_scan_unit.sv
// Directed bench for diff_scan_unit with default WIDTH=32, CHUNK=8.
// Expected latencies are given for both the fixed and early-exit builds.
module tb_diff_scan_unit;

`ifdef DIFF_SCAN_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic [5:0]  result;
  logic        result_valid;
  logic        result_ack;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  diff_scan_unit #(.WIDTH(32), .CHUNK(8)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .op_a         (op_a),
    .op_b         (op_b),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .result_ack   (result_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Wait for result_valid; n is the cycle number counted from the start cycle (0).
  task automatic wait_valid(input int from_cycle, output int n);
    n = from_cycle;
    while (!result_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input int exp_res, input int lat_fixed, input int lat_early);
    int n;
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid(1, n);
    check_val({tag, " latency"}, n, EARLY ? lat_early : lat_fixed);
    check_val({tag, " result"}, int'(result), exp_res);
    check_val({tag, " busy"}, int'(busy), 1);
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
    check_val({tag, " valid_cleared"}, int'(result_valid), 0);
    check_val({tag, " idle"}, int'(busy), 0);
  endtask

  initial begin
    int n;
    rst_n      = 1'b0;
    start      = 1'b0;
    op_a       = '0;
    op_b       = '0;
    result_ack = 1'b0;
    repeat (2) @(negedge clk);
    check_val("reset busy", int'(busy), 0);
    check_val("reset valid", int'(result_valid), 0);
    check_val("reset result", int'(result), 0);
    rst_n = 1'b1;

    run_op("bit0",     32'h0000_0000, 32'h0000_0001, 0,  5, 2);
    run_op("bit31",    32'hFFFF_FFFF, 32'h7FFF_FFFF, 31, 5, 5);
    run_op("equal",    32'hDEAD_BEEF, 32'hDEAD_BEEF, 32, 5, 5);
    run_op("bit8",     32'h0001_0100, 32'h0000_0000, 8,  5, 3);
    run_op("bit20",    32'h00F0_0000, 32'h0000_0000, 20, 5, 4);

    // Start and ack during SCAN must both be ignored.
    @(negedge clk);
    op_a  = 32'hFFFF_FFFF;
    op_b  = 32'h7FFF_FFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    op_a       = 32'h0000_0000;
    op_b       = 32'h0000_0001;
    start      = 1'b1;
    result_ack = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    result_ack = 1'b0;
    wait_valid(3, n);
    check_val("ignore latency", n, 5);
    check_val("ignore result", int'(result), 31);
    repeat (3) @(negedge clk);
    check_val("hold valid", int'(result_valid), 1);
    check_val("hold busy", int'(busy), 1);

    // Start coinciding with the ack is dropped; result value is retained.
    result_ack = 1'b1;
    start      = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
    start      = 1'b0;
    check_val("ack+start idle", int'(busy), 0);
    check_val("ack+start valid", int'(result_valid), 0);
    check_val("ack+start result kept", int'(result), 31);
    @(negedge clk);
    check_val("ack+start still idle", int'(busy), 0);

    // Leave result=8 behind, then reset during cycle 2 of a scan.
    run_op("bit8 again", 32'h0001_0100, 32'h0000_0000, 8, 5, 3);
    @(negedge clk);
    op_a  = 32'hFFFF_FFFF;
    op_b  = 32'h7FFF_FFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2;
    check_val("pre-reset busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check_val("async reset busy", int'(busy), 0);
    check_val("async reset valid", int'(result_valid), 0);
    check_val("async reset result", int'(result), 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("post-reset bit18", 32'h1234_0000, 32'h1230_0000, 18, 5, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

  // Absolute watchdog so the bench always terminates.
  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
